// File: rtl/rv32_core_pkg.sv
// rtl/rv32_core_pkg.sv - shared types and limits for the pipe_mux block
//   pipe_mux_state_t : occupancy of the two-entry output stage (EMPTY, ONE, TWO)
//   PIPE_MUX_N_MIN/MAX : legal range of the pipe_mux input count N
package rv32_core_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_mux_state_t;

    localparam int PIPE_MUX_N_MIN = 2;
    localparam int PIPE_MUX_N_MAX = 16;

endpackage

// File: rtl/pipe_mux_sel.sv
// rtl/pipe_mux_sel.sv - combinational N:1 word selector with out-of-range zeroing
//   in_data : N packed words, word k at [k*WIDTH +: WIDTH]
//   sel     : index of the word to pass
//   data    : selected word, 0 when sel >= N
//   err     : high when sel >= N
module pipe_mux_sel #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   data,
    output logic               err
);

    logic [31:0] sel_ext;

    assign sel_ext = 32'(sel);
    assign err     = (sel_ext >= 32'(N));

    // Compare-and-pick loop: an index with no matching k leaves data at 0,
    // which covers the unused codes when N is not a power of two.
    always_comb begin
        data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel_ext == 32'(k)) begin
                data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// rtl/pipe_mux.sv - registered N:1 mux with valid/ready handshake and skid buffer
//   clk, rst           : clock, synchronous active-high reset
//   in_data, sel       : packed inputs and index of the word to capture
//   in_valid, in_ready : upstream handshake (in_ready depends on state and rst only)
//   out_data           : main output register
//   out_valid, out_ready : downstream handshake
//   sel_err            : one-cycle pulse after a push with sel >= N
module pipe_mux
    import rv32_core_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    pipe_mux_state_t  state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] word;
    logic             word_err;
    logic             push;
    logic             pop;

    pipe_mux_sel #(
        .WIDTH (WIDTH),
        .N     (N),
        .SEL_W (SEL_W)
    ) u_sel (
        .in_data (in_data),
        .sel     (sel),
        .data    (word),
        .err     (word_err)
    );

    // in_ready only looks at the registered state, so there is never a
    // combinational path from out_ready back upstream.
    assign in_ready  = (state != TWO) && !rst;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            sel_err <= 1'b0;
        end else begin
            sel_err <= push && word_err;
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= word;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_q <= word;
                    end else if (push) begin
                        // Downstream stalled: park the new word behind main.
                        skid_q <= word;
                        state  <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each data input and of the output.
REQ-002 SHALL have parameter N, default 4, legal range 2..16: number of data inputs.
REQ-003 SHALL have parameter SEL_W, default $clog2(N): select width, derived and not overridden.
REQ-004 SHALL have clk, input, 1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have in_data, input, N*WIDTH: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have sel, input, SEL_W: index of the input to capture, sampled with in_data.
REQ-008 SHALL have in_valid, input, 1: upstream offers in_data/sel this cycle.
REQ-009 SHALL have in_ready, output, 1: block can accept this cycle.
REQ-010 SHALL have out_data, output, WIDTH: selected, registered word.
REQ-011 SHALL have out_valid, output, 1: out_data holds a word not yet consumed.
REQ-012 SHALL have out_ready, input, 1: downstream consumes out_data this cycle.
REQ-013 SHALL have sel_err, output, 1: one-cycle pulse when a word with sel >= N is accepted.

Function
REQ-014 SHALL accept a word ("push") when in_valid && in_ready, and SHALL release a word ("pop") when out_valid && out_ready.
REQ-015 SHALL have a latency of exactly 1 cycle: a word pushed at edge t appears on out_data/out_valid after edge t when the output register is empty.
REQ-016 SHALL store input[sel] for a push; if sel >= N it SHALL store 0 and assert sel_err the cycle after that edge.
REQ-017 SHALL hold 2 storage entries (main output register plus skid register), with state EMPTY, ONE or TWO.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO and 0 while rst is high. in_ready SHALL depend only on state and rst, never on out_ready.
REQ-019 SHALL drive out_valid = 1 in ONE and TWO, 0 in EMPTY; out_data SHALL always reflect the main register.
REQ-020 EMPTY: push -> ONE (main <= word); no push -> EMPTY.
REQ-021 ONE: push+pop -> ONE (main <= word); push only -> TWO (skid <= word); pop only -> EMPTY; neither -> ONE.
REQ-022 TWO: pop -> ONE (main <= skid); no pop -> TWO. A push is impossible here because in_ready = 0.
REQ-023 SHALL preserve order: words leave in exactly the order they were pushed; no word is dropped or duplicated.
REQ-024 SHALL keep out_data stable while out_valid && !out_ready.
REQ-025 sel_err SHALL be 0 on every cycle without an out-of-range push.

Reset
REQ-026 While rst is high at an edge, the block SHALL go to EMPTY, clear main and skid to 0, and clear sel_err. The cycle after, out_valid = 0, out_data = 0 and in_ready = 1.
REQ-027 Reset asserted mid-transfer (ONE or TWO) SHALL discard held words without popping them. A push attempted during reset SHALL be ignored.

Structure
REQ-028 Shared package rv32_core_pkg SHALL hold the state enum pipe_mux_state_t (EMPTY, ONE, TWO) and the N range limits.
REQ-029 The combinational N:1 selector with out-of-range zeroing SHALL be a sub-module, pipe_mux_sel (WIDTH, N), instantiated once. pipe_mux SHALL contain the FSM and registers.
REQ-030 There SHALL be no latches, and no combinational path from out_ready to in_ready.

Verification
REQ-031 The bench SHALL run a reset check: after rst is held 2 cycles then released -> out_valid = 0, out_data = 0, in_ready = 1, sel_err = 0.
REQ-032 The bench SHALL check basic select: N=4, inputs {0x44,0x33,0x22,0x11} (k=3..0), sel=2, push with out_ready = 1 -> next cycle out_data = 0x33 and out_valid = 1.
REQ-033 The bench SHALL check backpressure: out_ready = 0, push A=0xA then B=0xB -> in_ready = 0 after the 2nd edge; raise out_ready -> pops return 0xA then 0xB, and in_ready = 1 after the first pop.
REQ-034 The bench SHALL check streaming: in_valid = out_ready = 1 for 8 cycles with sel cycling 0..3 -> 8 words out in order, 1 per cycle, state stays ONE.
REQ-035 The bench SHALL check an out-of-range select: N=3, sel=3, push -> out_data = 0 and sel_err pulses for exactly 1 cycle.
REQ-036 The bench SHALL check reset mid-operation: in state TWO, assert rst for 1 cycle -> out_valid = 0, and neither held word is ever popped.
